// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-add multiplier.
//   state_t   : controller states
//   cnt_width : iteration-counter width, ceil(log2(bits+1))
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/mul_if.sv
// Request/result bundle for the multiplier.
//   a, b   : operands, sampled on a start cycle
//   start  : one-cycle request
//   p      : registered product (2*BITS)
//   busy   : multiplication in progress
//   rdy    : p holds a valid result, held until the next start
interface mul_if #(
    parameter int unsigned BITS = 32
);
    logic [BITS-1:0]   a;
    logic [BITS-1:0]   b;
    logic              start;
    logic [2*BITS-1:0] p;
    logic              busy;
    logic              rdy;

    modport master (output a, output b, output start,
                    input  p, input  busy, input  rdy);
    modport slave  (input  a, input  b, input  start,
                    output p, output busy, output rdy);
endinterface

// File: rtl/mul.sv
// Sequential LSB-first shift-add multiplier, one iteration per clock.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mul_if slave (a, b, start in; p, busy, rdy out)
// Build option: define MUL_SIGNED_EN for two's-complement operands/product
// (magnitudes are multiplied, then the result is negated in the NEG state).
// Without it operands are unsigned and NEG is unreachable.
module mul
    import mul_pkg::*;
#(
    parameter int unsigned BITS = 32
) (
    input  logic clk,
    input  logic rst_n,
    mul_if.slave bus
);

    localparam int unsigned PW = 2 * BITS;
    localparam int unsigned AW = PW + 1;
    localparam int unsigned HW = BITS + 1;
    localparam int unsigned CW = cnt_width(BITS);

    state_t          state;
    logic [AW-1:0]   acc;
    logic [BITS-1:0] mcand;
    logic [CW-1:0]   cnt;
    logic            sign;

    logic [BITS-1:0] mag_a_c;
    logic [BITS-1:0] mag_b_c;
    logic            sign_c;
    logic [HW-1:0]   sum_c;
    logic [AW-1:0]   step_c;
    logic            last_c;

    // Operand conditioning: magnitudes and result sign.
    // -2^(BITS-1) negates to itself, which read unsigned is 2^(BITS-1).
`ifdef MUL_SIGNED_EN
    always_comb begin
        mag_a_c = bus.a[BITS-1] ? BITS'(-bus.a) : bus.a;
        mag_b_c = bus.b[BITS-1] ? BITS'(-bus.b) : bus.b;
        sign_c  = bus.a[BITS-1] ^ bus.b[BITS-1];
    end
`else
    assign mag_a_c = bus.a;
    assign mag_b_c = bus.b;
    assign sign_c  = 1'b0;
    assign sign    = 1'b0;
`endif

    // One shift-add step: the upper half plus a carry bit absorbs the add,
    // then the whole accumulator shifts right. The multiplier occupies the
    // low half and is consumed from bit 0 as product bits shift in.
    always_comb begin
        sum_c = acc[AW-1:BITS];
        if (acc[0]) begin
            sum_c = acc[AW-1:BITS] + HW'(mcand);
        end
        step_c = {1'b0, sum_c, acc[BITS-1:1]};
        last_c = (cnt == CW'(BITS - 1));
    end

    // Controller and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            cnt      <= '0;
`ifdef MUL_SIGNED_EN
            sign     <= 1'b0;
`endif
            bus.p    <= '0;
            bus.rdy  <= 1'b0;
            bus.busy <= 1'b0;
        end else if (bus.start) begin
            // Start from any state aborts whatever was running; p is kept.
            state    <= RUN;
            mcand    <= mag_a_c;
            acc      <= AW'(mag_b_c);
            cnt      <= '0;
`ifdef MUL_SIGNED_EN
            sign     <= sign_c;
`endif
            bus.rdy  <= 1'b0;
            bus.busy <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    acc <= step_c;
                    cnt <= cnt + CW'(1);
                    if (last_c) begin
                        if (sign && (step_c[PW-1:0] != '0)) begin
                            state <= NEG;
                        end else begin
                            state    <= DONE;
                            bus.p    <= step_c[PW-1:0];
                            bus.rdy  <= 1'b1;
                            bus.busy <= 1'b0;
                        end
                    end
                end
`ifdef MUL_SIGNED_EN
                NEG: begin
                    acc      <= -acc;
                    bus.p    <= -acc[PW-1:0];
                    state    <= DONE;
                    bus.rdy  <= 1'b1;
                    bus.busy <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul at BITS=8: directed operations with a
// scoreboard of expected products/latencies, restart, reset, hold.
module tb_mul;

    localparam int unsigned BITS = 8;
    localparam int unsigned PW   = 16;

    typedef struct {
        logic [PW-1:0] p;
        int            lat;
        string         tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    mul_if #(.BITS(BITS)) bus ();

    mul #(.BITS(BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive a start cycle; returns 1 time unit after the start edge.
    task automatic launch(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        chk("rdy_after_start",  64'(bus.rdy),  64'd0);
    endtask

    task automatic push(input logic [PW-1:0] p, input int lat, input string tag);
        exp_t e;
        e.p   = p;
        e.lat = lat;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Count edges after the start edge until rdy, then check against the
    // oldest scoreboard entry.
    task automatic wait_result(output logic [PW-1:0] got_p);
        exp_t e;
        int   edges;
        bit   seen;
        e     = sb.pop_front();
        edges = 0;
        seen  = 1'b0;
        got_p = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.rdy === 1'b1) begin
                edges = i;
                seen  = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk({e.tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({e.tag, "_latency"}, 64'(edges), 64'(e.lat));
            chk({e.tag, "_p"}, 64'(bus.p), 64'(e.p));
            chk({e.tag, "_busy"}, 64'(bus.busy), 64'd0);
            got_p = bus.p;
        end
    endtask

    initial begin
        logic [PW-1:0]   held;
        logic [PW-1:0]   pa;
        logic [PW-1:0]   pb;
        logic [BITS-1:0] ra;
        logic [BITS-1:0] rb;
        logic [PW-1:0]   last_exp;

        bus.a     = '0;
        bus.b     = '0;
        bus.start = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_p",    64'(bus.p),    64'd0);
        chk("reset_rdy",  64'(bus.rdy),  64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifdef MUL_SIGNED_EN
        launch(8'hFD, 8'd5);
        push(16'hFFF1, 9, "s_m3x5");
        wait_result(held);

        launch(8'h80, 8'h80);
        push(16'h4000, 8, "s_m128xm128");
        wait_result(held);

        launch(8'hF9, 8'd0);
        push(16'h0000, 8, "s_m7x0");
        wait_result(held);
`else
        launch(8'd13, 8'd11);
        push(16'd143, 8, "u_13x11");
        wait_result(held);

        launch(8'd255, 8'd255);
        push(16'hFE01, 8, "u_255x255");
        wait_result(held);

        launch(8'd0, 8'd200);
        push(16'd0, 8, "u_0x200");
        wait_result(held);

        for (int k = 0; k < 3; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            pa = {8'd0, ra};
            pb = {8'd0, rb};
            launch(ra, rb);
            push(pa * pb, 8, "u_rand");
            wait_result(held);
        end
`endif

        // Restart while busy: only the second job may complete.
        launch(8'd5, 8'd7);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("restart_no_rdy", 64'(bus.rdy), 64'd0);
        end
        launch(8'd9, 8'd9);
        push(16'd81, 8, "restart_9x9");
        last_exp = 16'd81;
        wait_result(held);

        // Operand changes without start leave the result alone.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            @(posedge clk);
            #1;
            chk("hold_rdy_p", 64'({bus.rdy, bus.p}), 64'({1'b1, last_exp}));
        end

        // Start while rdy: rdy drops at the start edge, p keeps old value.
        launch(8'd100, 8'd3);
        chk("restart_from_done_p", 64'(bus.p), 64'(last_exp));
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_p",    64'(bus.p),    64'd0);
        chk("midrst_rdy",  64'(bus.rdy),  64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);

        // start is ignored while reset is held.
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_in_reset_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b1;

        launch(8'd2, 8'd3);
        push(16'd6, 8, "post_reset_2x3");
        wait_result(held);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul.md
MUL -- requirements
Module: mul

Interface
REQ-001 SHALL have parameter: BITS, 32, operand width; legal values 2..64.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: a  input  BITS  multiplicand, sampled only on a start cycle.
REQ-005 SHALL have port: b  input  BITS  multiplier, sampled only on a start cycle.
REQ-006 SHALL have port: start  input  1  one-cycle request; latches a and b.
REQ-007 SHALL have port: p  output  2*BITS  product, registered.
REQ-008 SHALL have port: busy  output  1  high while a multiplication is in progress.
REQ-009 SHALL have port: rdy  output  1  high while p holds a valid result; held until the next start.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, NEG, DONE.
REQ-011 SHALL move from any state to RUN on a start edge: latch a and b; clear accumulator and iteration counter; rdy=0; busy=1.
REQ-012 RUN: one shift-add step per clock, LSB-first; add the multiplicand to the upper half of the accumulator when the current multiplier bit is 1; then shift right 1 with carry-in; BITS iterations.
REQ-013 SHALL keep the accumulator 2*BITS+1 bits wide so the adder carry is never lost; p SHALL equal the exact a*b modulo 2^(2*BITS).
REQ-014 SHALL go from RUN to NEG after the last iteration when the result sign flag is set, otherwise straight to DONE.
REQ-015 NEG: two's-complement negate the accumulator in one cycle, then go to DONE.
REQ-016 DONE and IDLE: p is held; rdy=1 only in DONE; busy=0 in both.
REQ-017 Latency: rdy SHALL rise on rising edge BITS after the start edge; add one edge when NEG is taken.
REQ-018 start while busy SHALL abort the current operation and restart with the new operands; no rdy pulse for the aborted job.
REQ-019 start while rdy=1 SHALL drop rdy at that same edge; p keeps its old value until the new result is written.
REQ-020 Input changes on a or b outside a start cycle SHALL have no effect.
REQ-021 Zero operands SHALL take the full latency; no early exit.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, p=0, rdy=0, busy=0, accumulator=0, counter=0, regardless of clk.
REQ-023 A reset asserted mid-operation SHALL discard that operation; the first start after release SHALL behave normally.
REQ-024 start SHALL be ignored while rst_n is low.

Configuration
REQ-025 Macro MUL_SIGNED_EN defined: a, b and p are two's complement.
  - At start, store the magnitudes of a and b and sign flag = a[BITS-1] XOR b[BITS-1].
  - NEG is taken when the sign flag is set and the magnitude product is nonzero.
  - The magnitude of -2^(BITS-1) SHALL be handled as unsigned 2^(BITS-1).
REQ-026 MUL_SIGNED_EN undefined: operands and p unsigned; sign flag tied to 0; NEG unreachable and optimised away.

Structure
REQ-027 Package mul_pkg SHALL hold the state enum typedef and the iteration-counter width function, ceil(log2(BITS+1)).
REQ-028 Single module; no sub-module (datapath is one adder plus a shifter).

Verification (BITS=8)
REQ-029 Unsigned: a=13, b=11, start -> rdy at edge 8, p=16'd143, busy low with rdy.
REQ-030 Unsigned: a=255, b=255 -> p=16'hFE01; a=0, b=200 -> p=0 at edge 8.
REQ-031 Restart: start a=5, b=7; at edge 3 start a=9, b=9 -> a single rdy at edge 11 (8 after the restart), p=81; no rdy for 5*7.
REQ-032 Reset: start a=100, b=3; drop rst_n at edge 4 -> outputs zero immediately; after release, a=2, b=3 -> p=6.
REQ-033 MUL_SIGNED_EN: a=-3, b=5 -> rdy at edge 9, p=16'hFFF1; a=-128, b=-128 -> rdy at edge 8, p=16'h4000; a=-7, b=0 -> rdy at edge 8, p=0.
REQ-034 Hold: after rdy, toggle a and b without start for 20 cycles -> p and rdy unchanged.
